vc_plane_buffer: RTL and testbench

VC_PLANE_BUFFER -- requirements
Module: vc_plane_buffer

---
 rtl/vc_plane_buffer_if.sv | 30 +++
 rtl/vc_plane_buffer.sv | 100 ++++++++++
 tb/tb_vc_plane_buffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vc_plane_buffer_if.sv
// Bus between the plane controller / router (master) and the VC plane buffer (slave).
// Flit input, plane selector, flit output and per-plane status flags.
interface vc_plane_buffer_if #(
   parameter int VC         = 4,
   parameter int NUM_VC     = 4,
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_data;
   logic [VC:0]           in_vc;
   logic                  in_valid;
   logic                  in_ready;
   logic [VC:0]           VCPlaneSelector;
   logic [DATA_WIDTH-1:0] out_data;
   logic [VC:0]           out_vc;
   logic                  out_valid;
   logic                  out_ready;
   logic [NUM_VC-1:0]     vc_empty;
   logic [NUM_VC-1:0]     vc_full;
   logic                  err_oob;

   modport master (
      output in_data, in_vc, in_valid, VCPlaneSelector, out_ready,
      input  in_ready, out_data, out_vc, out_valid, vc_empty, vc_full, err_oob
   );

   modport slave (
      input  in_data, in_vc, in_valid, VCPlaneSelector, out_ready,
      output in_ready, out_data, out_vc, out_valid, vc_empty, vc_full, err_oob
   );
endinterface

// File: rtl/vc_plane_buffer.sv
// Per-VC-plane flit buffer: NUM_VC independent first-word-fall-through FIFOs,
// written by in_vc, read by the controller-driven plane selector.
module vc_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  empty,
   output logic                  full
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [AW:0]           cnt;

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      cnt <= cnt + (AW+1)'(1);
         else if (pop && !push) cnt <= cnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module vc_plane_buffer #(
   parameter int VC         = 4,
   parameter int NUM_VC     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input logic              clk,
   input logic              rst,
   vc_plane_buffer_if.slave bus
);
   logic [NUM_VC-1:0]                 wr_hit, rd_hit, push, pop, empty, full;
   logic [NUM_VC-1:0][DATA_WIDTH-1:0] head;
   logic                              in_oob, err_q;
   logic [DATA_WIDTH-1:0]             rd_data;

   assign in_oob = (bus.in_vc >= (VC+1)'(NUM_VC));

   // Plane decode by equality keeps out-of-range indices from selecting anything
   for (genvar g = 0; g < NUM_VC; g++) begin : g_plane
      assign wr_hit[g] = (bus.in_vc == (VC+1)'(g));
      assign rd_hit[g] = (bus.VCPlaneSelector == (VC+1)'(g));
      assign push[g]   = bus.in_valid & wr_hit[g] & ~full[g];
      assign pop[g]    = bus.out_ready & rd_hit[g] & ~empty[g];

      vc_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .wdata (bus.in_data),
         .pop   (pop[g]),
         .rdata (head[g]),
         .empty (empty[g]),
         .full  (full[g])
      );
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_VC; i++)
         if (rd_hit[i] && !empty[i]) rd_data = rd_data | head[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         err_q <= 1'b0;
      else if (bus.in_valid && in_oob)  err_q <= 1'b1;
   end

   // Full plane refuses even when popped this cycle: ready uses the registered count
   assign bus.in_ready  = in_oob | (|(wr_hit & ~full));
   assign bus.out_valid = |(rd_hit & ~empty);
   assign bus.out_data  = rd_data;
   assign bus.out_vc    = bus.VCPlaneSelector;
   assign bus.vc_empty  = empty;
   assign bus.vc_full   = full;
   assign bus.err_oob   = err_q;
endmodule

// File: tb/tb_vc_plane_buffer.sv
// Bench for vc_plane_buffer: queue-based plane model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vc_plane_buffer;
   localparam int VC = 4, NUM_VC = 4, DW = 32, DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vecs = 0;
   int   errs = 0;

   vc_plane_buffer_if #(.VC(VC), .NUM_VC(NUM_VC), .DATA_WIDTH(DW)) bus ();

   vc_plane_buffer #(.VC(VC), .NUM_VC(NUM_VC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: one queue per plane plus the sticky error bit
   logic [DW-1:0] mq [NUM_VC][$];
   bit            merr;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      int s, v;
      bit do_pop, do_push;
      if (!rst) begin
         for (int i = 0; i < NUM_VC; i++) mq[i].delete();
         merr = 1'b0;
      end else begin
         s = int'(bus.VCPlaneSelector);
         v = int'(bus.in_vc);
         do_pop  = bus.out_ready && s < NUM_VC && mq[s].size() > 0;
         do_push = bus.in_valid && v < NUM_VC && mq[v].size() < DEPTH;
         if (bus.in_valid && v >= NUM_VC) merr = 1'b1;
         if (do_pop)  void'(mq[s].pop_front());
         if (do_push) mq[v].push_back(bus.in_data);
      end
   end

   always @(negedge clk) begin
      int s, v;
      logic [NUM_VC-1:0] ee, ef;
      logic              evld, erdy;
      logic [DW-1:0]     edat;
      s = int'(bus.VCPlaneSelector);
      v = int'(bus.in_vc);
      for (int i = 0; i < NUM_VC; i++) begin
         ee[i] = (mq[i].size() == 0);
         ef[i] = (mq[i].size() == DEPTH);
      end
      evld = (s < NUM_VC) && (mq[s].size() > 0);
      edat = '0;
      if (evld) edat = mq[s][0];
      erdy = (v >= NUM_VC) || (mq[v].size() < DEPTH);
      chk("in_ready",  32'(bus.in_ready),  32'(erdy));
      chk("out_valid", 32'(bus.out_valid), 32'(evld));
      chk("out_data",  bus.out_data,       edat);
      chk("out_vc",    32'(bus.out_vc),    32'(s));
      chk("vc_empty",  32'(bus.vc_empty),  32'(ee));
      chk("vc_full",   32'(bus.vc_full),   32'(ef));
      chk("err_oob",   32'(bus.err_oob),   32'(merr));
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit v, int vc, logic [DW-1:0] d, int sel, bit ordy);
      bus.in_valid        = v;
      bus.in_vc           = (VC+1)'(vc);
      bus.in_data         = d;
      bus.VCPlaneSelector = (VC+1)'(sel);
      bus.out_ready       = ordy;
   endtask

   initial begin
      drive(0, 0, '0, 0, 0);
      // reset state
      #2;
      chk("rst_empty", 32'(bus.vc_empty), 32'hF);
      chk("rst_full",  32'(bus.vc_full),  32'h0);
      chk("rst_oval",  32'(bus.out_valid), 32'h0);
      chk("rst_odata", bus.out_data, 32'h0);
      drive(0, 7, '0, 0, 0);
      #1 chk("rst_rdy_oob", 32'(bus.in_ready), 32'h1);
      drive(0, 1, '0, 0, 0);
      #1 chk("rst_rdy_p1", 32'(bus.in_ready), 32'h1);
      tick;
      tick;
      rst = 1'b1;

      // basic: two flits through plane 2
      drive(1, 2, 32'hA1, 2, 1);
      #1 chk("basic_ov0", 32'(bus.out_valid), 32'h0);
      tick;
      drive(1, 2, 32'hA2, 2, 1);
      #1 chk("basic_a1", bus.out_data, 32'hA1);
      tick;
      drive(0, 2, '0, 2, 1);
      #1 chk("basic_a2", bus.out_data, 32'hA2);
      tick;
      #1 chk("basic_ov_end", 32'(bus.out_valid), 32'h0);
      chk("basic_empty2", 32'(bus.vc_empty[2]), 32'h1);

      // full plane 1
      for (int k = 0; k < DEPTH; k++) begin
         drive(1, 1, 32'hB0 + k, 1, 0);
         tick;
      end
      drive(1, 1, 32'hBF, 1, 0);
      #1 chk("full_flag", 32'(bus.vc_full[1]), 32'h1);
      chk("full_rdy", 32'(bus.in_ready), 32'h0);
      tick;
      drive(0, 1, '0, 1, 1);
      #1 chk("full_head", bus.out_data, 32'hB0);
      tick;
      #1 chk("full_drop", 32'(bus.vc_full[1]), 32'h0);
      chk("full_b1", bus.out_data, 32'hB1);
      tick;
      tick;
      tick;
      #1 chk("full_no5th", 32'(bus.out_valid), 32'h0);

      // concurrent push/pop on plane 0
      drive(1, 0, 32'hC0, 0, 0);
      tick;
      drive(1, 0, 32'hC1, 0, 0);
      tick;
      drive(1, 0, 32'hC2, 0, 1);
      #1 chk("conc_c0", bus.out_data, 32'hC0);
      tick;
      drive(0, 0, '0, 0, 0);
      #1 chk("conc_c1", bus.out_data, 32'hC1);
      drive(0, 0, '0, 0, 1);
      tick;
      #1 chk("conc_c2", bus.out_data, 32'hC2);
      tick;
      #1 chk("conc_empty", 32'(bus.vc_empty[0]), 32'h1);

      // plane switching
      drive(1, 0, 32'hD0, 1, 0);
      tick;
      drive(1, 3, 32'hD3, 1, 0);
      tick;
      drive(0, 0, '0, 0, 1);
      #1 chk("sw_d0", bus.out_data, 32'hD0);
      tick;
      drive(0, 0, '0, 3, 1);
      #1 chk("sw_d3", bus.out_data, 32'hD3);
      tick;
      drive(0, 0, '0, 1, 1);
      #1 chk("sw_p1", 32'(bus.out_valid), 32'h0);
      tick;
      drive(0, 0, '0, 0, 1);
      #1 chk("sw_nodup0", 32'(bus.out_valid), 32'h0);
      drive(0, 0, '0, 3, 1);
      #1 chk("sw_nodup3", 32'(bus.out_valid), 32'h0);

      // out-of-range write and selector
      drive(1, 5, 32'hEE, 0, 0);
      #1 chk("oob_rdy", 32'(bus.in_ready), 32'h1);
      chk("oob_err0", 32'(bus.err_oob), 32'h0);
      tick;
      drive(0, 0, '0, 4, 1);
      #1 chk("oob_err1", 32'(bus.err_oob), 32'h1);
      chk("oob_empty", 32'(bus.vc_empty), 32'hF);
      chk("oob_sel", 32'(bus.out_valid), 32'h0);

      // asynchronous reset with flits buffered
      drive(1, 0, 32'hE0, 1, 0);
      tick;
      drive(1, 1, 32'hE1, 1, 0);
      tick;
      drive(1, 2, 32'hE2, 1, 0);
      tick;
      drive(0, 1, '0, 1, 0);
      #1 chk("ar_pre", bus.out_data, 32'hE1);
      rst = 1'b0;
      #1 chk("ar_oval", 32'(bus.out_valid), 32'h0);
      chk("ar_empty", 32'(bus.vc_empty), 32'hF);
      chk("ar_err", 32'(bus.err_oob), 32'h0);
      chk("ar_rdy", 32'(bus.in_ready), 32'h1);
      tick;
      rst = 1'b1;
      drive(1, 1, 32'hF5, 1, 0);
      tick;
      drive(0, 1, '0, 1, 0);
      #1 chk("ar_new", bus.out_data, 32'hF5);

      // randomized traffic, pop pressure varied per phase
      for (int n = 0; n < 3000; n++) begin
         int vc, sel, opct;
         opct = ((n / 400) % 3 == 0) ? 20 : (((n / 400) % 3 == 1) ? 90 : 55);
         vc   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 31)) : int'($urandom_range(0, 3));
         sel  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 31)) : int'($urandom_range(0, 3));
         drive($urandom_range(0, 3) != 0, vc, $urandom, sel, $urandom_range(0, 99) < opct);
         if (n == 1700) begin
            #1 rst = 1'b0;
            tick;
            rst = 1'b1;
         end else begin
            tick;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
